serial_tx_6b: RTL and testbench

Parallel-in, serial-out transmitter that feeds the `ShiftReg_6b` bit-in/shift protocol from the opposite end. It accepts a WIDTH-bit word over a valid/ready handshake and replays it MSB-first on `BitOut`. Each bit is accompanied by a one-cycle `ShiftOut` strobe, so a downstream `ShiftReg_6b` holds the complete word after WIDTH strobes. It sits between game logic that produces segment patterns and any shift-register chain driving the display.

---
 rtl/serial_tx_pkg.sv | 9 +
 rtl/serial_tx_6b_bit_period_ctr.sv | 23 ++
 rtl/serial_tx_6b.sv | 75 +++++++
 tb/tb_serial_tx_6b.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state type, default sizing and counter-width helper for serial_tx_6b.
package serial_tx_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 6;
  localparam int DEF_DIV   = 1;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_tx_6b_bit_period_ctr.sv
// bit_period_ctr: loadable DIV-1 down-counter whose terminal count marks the last cycle of a bit period.
module bit_period_ctr
  import serial_tx_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  logic [CW-1:0] r_cnt;
  logic          w_tc;
  assign w_tc = r_cnt == '0;
  assign o_tc = w_tc;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load || (i_en && w_tc)) r_cnt <= RELOAD;
    else if (i_en) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/serial_tx_6b.sv
// serial_tx_6b: valid/ready parallel-in, MSB-first serial-out transmitter with per-bit shift strobe.
// Optional Abort input enabled by defining SERIAL_TX_ABORT_EN.
module serial_tx_6b
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef SERIAL_TX_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_bit_out,
  output logic             o_shift_out,
  output logic             o_busy,
  output logic             o_done
);
  localparam int BW = cnt_w(WIDTH + 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic [BW-1:0]    r_cnt;
  logic             r_done;
  logic             w_tc, w_accept, w_shift, w_abort;
`ifdef SERIAL_TX_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif
  assign w_shift  = r_state == SHIFT;
  assign w_accept = (r_state == IDLE) && i_valid;
  bit_period_ctr #(.DIV(DIV)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_en    (w_shift),
    .o_tc    (w_tc)
  );
  // Outputs decode registered state only, so reset drives them immediately.
  assign o_ready     = !w_shift;
  assign o_busy      = w_shift;
  assign o_bit_out   = w_shift & r_buf[WIDTH-1];
  assign o_shift_out = w_shift & w_tc;
  assign o_done      = r_done;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_valid) begin
          r_buf   <= i_data_in;
          r_cnt   <= BW'(WIDTH);
          r_state <= SHIFT;
        end
      end else if (w_abort) begin
        r_state <= IDLE;
        r_buf   <= '0;
        r_cnt   <= '0;
      end else if (w_tc) begin
        r_buf <= {r_buf[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == BW'(1)) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_serial_tx_6b.sv
// tb_serial_tx_6b: checks serial_tx_6b at DIV=1 and DIV=3 against a cycle-level frame model and a receiver model.
module tb_serial_tx_6b;
  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       valid [2];
  logic       abort [2];
  logic [5:0] data  [2];
  logic [1:0] rdy, bo, so, busy, done;
  logic [5:0] rx    [2];
  int         nstb  [2];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  serial_tx_6b #(.WIDTH(6), .DIV(1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n[0]),
`ifdef SERIAL_TX_ABORT_EN
    .i_abort(abort[0]),
`endif
    .i_data_in(data[0]), .i_valid(valid[0]), .o_ready(rdy[0]), .o_bit_out(bo[0]),
    .o_shift_out(so[0]), .o_busy(busy[0]), .o_done(done[0]));

  serial_tx_6b #(.WIDTH(6), .DIV(3)) u1 (
    .i_clk(clk), .i_rst_n(rst_n[1]),
`ifdef SERIAL_TX_ABORT_EN
    .i_abort(abort[1]),
`endif
    .i_data_in(data[1]), .i_valid(valid[1]), .o_ready(rdy[1]), .o_bit_out(bo[1]),
    .o_shift_out(so[1]), .o_busy(busy[1]), .o_done(done[1]));

  // Downstream ShiftReg_6b: samples BitIn on every edge that ends a Shift cycle.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (so[i]) begin
        rx[i]   <= {rx[i][4:0], bo[i]};
        nstb[i] <= nstb[i] + 1;
      end

  function automatic int per(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int u, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d t=%0t got=%b want=%b", name, u, $time, act, exp);
    end
  endtask

  // Called at a negedge with data/valid already presented; checks every cycle of the frame.
  task automatic run_frame(input int u, input logic [5:0] w, input bit noise, input bit chain, input logic [5:0] nxt);
    int p, last, s0;
    logic [5:0] e_bit, e_so;
    p = per(u);
    last = 6 * p + 1;
    chk("pre_ready", u, {5'd0, rdy[u]}, 6'd1);
    s0 = nstb[u];
    @(posedge clk);
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      e_so  = {5'd0, (j <= 6 * p) && (j % p == 0)};
      e_bit = (j <= 6 * p) ? {5'd0, w[5 - (j - 1) / p]} : 6'd0;
      chk("shift", u, {5'd0, so[u]}, e_so);
      chk("bit", u, {5'd0, bo[u]}, e_bit);
      chk("busy", u, {5'd0, busy[u]}, {5'd0, j <= 6 * p});
      chk("ready", u, {5'd0, rdy[u]}, {5'd0, j == last});
      chk("done", u, {5'd0, done[u]}, {5'd0, j == last});
      abort[u] = 1'b0;
      valid[u] = noise ? 1'($urandom) : 1'b0;
      data[u]  = 6'($urandom);
      if (j == last) begin
        valid[u] = chain;
        data[u]  = nxt;
      end
    end
    chk("rx_word", u, rx[u], w);
    chk("strobes", u, 6'(nstb[u] - s0), 6'd6);
  endtask

  task automatic test_reset;
    for (int u = 0; u < 2; u++) begin
      chk("rst_ready", u, {5'd0, rdy[u]}, 6'd1);
      chk("rst_outs", u, {2'd0, bo[u], so[u], busy[u], done[u]}, 6'd0);
    end
  endtask

  task automatic test_basic;
    @(negedge clk);
    data[0] = 6'b110010; valid[0] = 1'b1;
    run_frame(0, 6'b110010, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    data[1] = 6'b100001; valid[1] = 1'b1;
    run_frame(1, 6'b100001, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    data[0] = 6'b101010; valid[0] = 1'b1;
    run_frame(0, 6'b101010, 1'b0, 1'b1, 6'b010101);
    run_frame(0, 6'b010101, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic test_valid_ignored;
    @(negedge clk);
    data[0] = 6'b000011; valid[0] = 1'b1;
    run_frame(0, 6'b000011, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    data[1] = 6'b000011; valid[1] = 1'b1;
    run_frame(1, 6'b000011, 1'b1, 1'b0, 6'd0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    data[0] = 6'b101101; valid[0] = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      valid[0] = 1'b0;
    end
    chk("pre_rst_busy", 0, {5'd0, busy[0]}, 6'd1);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("async_ready", 0, {5'd0, rdy[0]}, 6'd1);
    chk("async_outs", 0, {2'd0, bo[0], so[0], busy[0], done[0]}, 6'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("no_done", 0, {4'd0, done[0], so[0]}, 6'd0);
    end
    data[0] = 6'b011001; valid[0] = 1'b1;
    run_frame(0, 6'b011001, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic test_random;
    logic [5:0] w, n;
    bit c;
    for (int u = 0; u < 2; u++) begin
      @(negedge clk);
      w = 6'($urandom);
      data[u] = w; valid[u] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        n = 6'($urandom);
        c = (k < 7) && 1'($urandom);
        run_frame(u, w, 1'($urandom), c, n);
        if (!c) begin
          @(negedge clk);
          data[u] = n; valid[u] = 1'b1;
        end
        w = n;
      end
      run_frame(u, w, 1'b0, 1'b0, 6'd0);
    end
  endtask

`ifdef SERIAL_TX_ABORT_EN
  task automatic test_abort;
    int s0;
    @(negedge clk);
    data[1] = 6'b111111; valid[1] = 1'b1;
    s0 = nstb[1];
    @(posedge clk);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      valid[1] = 1'b0;
      if (j == 7) abort[1] = 1'b1;
    end
    @(negedge clk);
    abort[1] = 1'b0;
    chk("abort_ready", 1, {5'd0, rdy[1]}, 6'd1);
    chk("abort_outs", 1, {3'd0, bo[1], so[1], busy[1]}, 6'd0);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("abort_quiet", 1, {4'd0, done[1], so[1]}, 6'd0);
    end
    chk("abort_strobes", 1, 6'(nstb[1] - s0), 6'd2);
    abort[1] = 1'b1; data[1] = 6'b010011; valid[1] = 1'b1;
    run_frame(1, 6'b010011, 1'b0, 1'b0, 6'd0);
  endtask
`endif

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; valid[u] = 1'b0; abort[u] = 1'b0; data[u] = '0;
      rx[u] = '0; nstb[u] = 0;
    end
    #2;
    test_reset;
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    test_basic;
    test_back_to_back;
    test_valid_ignored;
    test_async_reset;
    test_random;
`ifdef SERIAL_TX_ABORT_EN
    test_abort;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
